arm_exec_stage: RTL and testbench
=================================

Name: arm_exec_stage

Overview:
- Execute stage directly downstream of instruction decode and the register file.
- Consumes decoded data-processing fields and the two register operands.
- Evaluates the ARM condition code against an internal NZCV flag register, computes the ALU result and updates the flags.
- Presents a registered result and write-back request to the write-back stage through a valid/ready handshake.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset ({N,Z,C,V}, N in bit 3).
- CNT_WIDTH, 16, width of the optional performance counters.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage can accept this cycle
- in_cond  input  4  ARM condition field, inst[31:28]
- in_opcode  input  4  data-processing opcode, inst[24:21]
- in_set_flags  input  1  S bit
- in_src_a  input  32  Rn operand
- in_src_b  input  32  Rm operand / immediate
- in_write_reg  input  4  destination register
- flush  input  1  squash the held result and block acceptance this cycle
- out_valid  output  1  result register holds an instruction
- out_ready  input  1  write-back consumes the result
- out_result  output  32  ALU result
- out_write_reg  output  4  destination register
- out_write_en  output  1  write-back request (0 for squashed or compare ops)
- out_cond_pass  output  1  condition evaluated true for the held instruction
- flags  output  4  current NZCV register
- exec_count  output  CNT_WIDTH  executed-instruction counter (optional feature)
- squash_count  output  CNT_WIDTH  condition-failed counter (optional feature)

Behaviour:
- Reset: out_valid=0, out_result=0, out_write_reg=0, out_write_en=0, out_cond_pass=0, flags=RESET_FLAGS, counters=0.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept occurs when in_valid && in_ready. Latency is 1 cycle: accepted in cycle t, visible with out_valid=1 in cycle t+1.
  - The output register holds its contents while out_valid && !out_ready.
  - Full throughput when out_ready is held high.
- Condition evaluation is combinational on the registered flags at accept time:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F NV 0.
- Opcodes:
  - 0 AND; 1 EOR; 2 SUB a-b; 3 RSB b-a; 4 ADD; 5 ADC a+b+C; 6 SBC a-b-!C; 7 RSC b-a-!C.
  - 8 TST (AND); 9 TEQ (EOR); A CMP (SUB); B CMN (ADD).
  - C ORR; D MOV b; E BIC a&~b; F MVN ~b.
- Arithmetic is performed at 33 bits.
  - C = carry out for add types; C = NOT borrow for subtract types.
  - V = signed overflow of the 32-bit result.
- Flag update happens on accept only, when cond passes and (in_set_flags or opcode 8..B):
  - N=result[31], Z=(result==0).
  - C and V are updated only for arithmetic ops; logical ops leave C and V unchanged (there is no shifter).
- out_write_en = cond_pass && opcode not in 8..B.
- A condition-failed instruction still occupies the slot (out_valid=1) with out_write_en=0, out_result=0 and no flag change.
- Back-to-back: flags written on accept are visible to the next accept in the following cycle. There is no hazard.
- Flush: out_valid clears on the next edge, regardless of out_ready, and nothing is accepted that cycle. Flags written by earlier accepts are not rolled back.
- Reset mid-stall drops the held result.

Optional Feature:
- ARM_EXEC_PERF_CNT_EN defined:
  - exec_count increments on every accept with cond_pass.
  - squash_count increments on every accept with !cond_pass.
  - Both saturate at all-ones and both clear on reset.
- Undefined: counter logic is omitted and both ports are driven 0.

Decomposition:
- Shared package/include (arm_constants.v): condition-code constants COND_EQ..COND_NV, opcode constants OP_AND..OP_MVN, NZCV bit indices.
- One sub-module is natural: arm_cond_eval (4-bit cond + NZCV -> pass), combinational and reusable by the branch logic.
- ALU and output register stay in this module.

Test Plan:
- Reset with RESET_FLAGS=0 -> flags=0000, out_valid=0, in_ready=1. Then ADD AL a=5 b=7 S=1 -> next cycle out_result=12, out_write_en=1, flags=0000.
- CMP AL S=0 a=3 b=3 -> out_write_en=0, flags=0110 (Z=1, C=1). Next cycle MOVEQ b=0xAB -> out_result=0xAB, out_cond_pass=1. Then MOVNE -> out_write_en=0, out_result=0.
- ADDS a=0x7FFFFFFF b=1 -> result 0x80000000, flags N=1 V=1 Z=0 C=0. Then ADDS a=0xFFFFFFFF b=1 -> result 0, Z=1 C=1 V=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_result stable, flags unchanged. Release -> exactly one further accept per cycle.
- Assert flush with out_valid=1, out_ready=0 -> out_valid=0 next cycle, in_ready=0 during the flush cycle. Assert reset while stalled -> all outputs return to reset values.
- With ARM_EXEC_PERF_CNT_EN: 4 AL instructions plus 2 NV instructions -> exec_count=4, squash_count=2. Without the macro -> both counters read 0.

Source files
------------

// File: rtl/arm_exec_stage_pkg.sv
// Shared constants for the ARM execute stage: condition codes, data-processing
// opcodes, NZCV bit positions and opcode classification helpers.
package arm_exec_stage_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN: always set flags, never write back
  function automatic logic is_compare(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  // ops whose C/V come from the adder
  function automatic logic is_arith(input logic [3:0] op);
    return (op >= OP_SUB && op <= OP_RSC) || op == OP_CMP || op == OP_CMN;
  endfunction

endpackage

// File: rtl/arm_cond_eval.sv
// ARM condition-code evaluator: 4-bit cond field + NZCV -> pass.
// Purely combinational so the branch unit can reuse it.
module arm_cond_eval
  import arm_exec_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // decode the condition against the current flags
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_exec_stage.sv
// ARM execute stage: condition check, 32-bit ALU, NZCV register and a single
// registered result slot toward write-back (valid/ready, 1-cycle latency).
// Optional feature macro: ARM_EXEC_PERF_CNT_EN enables saturating exec/squash
// counters; otherwise both counter ports read 0.
module arm_exec_stage
  import arm_exec_stage_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_cond,
  input  logic [3:0]           in_opcode,
  input  logic                 in_set_flags,
  input  logic [31:0]          in_src_a,
  input  logic [31:0]          in_src_b,
  input  logic [3:0]           in_write_reg,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [3:0]           out_write_reg,
  output logic                 out_write_en,
  output logic                 out_cond_pass,
  output logic [3:0]           flags,
  output logic [CNT_WIDTH-1:0] exec_count,
  output logic [CNT_WIDTH-1:0] squash_count
);

  logic        accept, cond_pass, arith, ovf, cin;
  logic [31:0] opx, opy, logic_res, alu_res;
  logic [32:0] sum;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  arm_cond_eval u_cond (
    .cond (in_cond),
    .nzcv (flags),
    .pass (cond_pass)
  );

  // steer operands so every arithmetic op is x + y + cin; subtracts invert y,
  // which makes the adder carry-out directly the ARM "NOT borrow" C flag
  always_comb begin
    opx = in_src_a;
    opy = ~in_src_b;
    cin = 1'b1;
    case (in_opcode)
      OP_RSB: begin opx = in_src_b; opy = ~in_src_a; end
      OP_ADD, OP_CMN: begin opy = in_src_b; cin = 1'b0; end
      OP_ADC: begin opy = in_src_b; cin = flags[FLAG_C]; end
      OP_SBC: cin = flags[FLAG_C];
      OP_RSC: begin opx = in_src_b; opy = ~in_src_a; cin = flags[FLAG_C]; end
      default: ;
    endcase
  end

  assign sum = {1'b0, opx} + {1'b0, opy} + {32'b0, cin};
  assign ovf = (opx[31] == opy[31]) && (sum[31] != opx[31]);

  // logical results (no shifter, so these never produce C/V)
  always_comb begin
    logic_res = '0;
    case (in_opcode)
      OP_AND, OP_TST: logic_res = in_src_a & in_src_b;
      OP_EOR, OP_TEQ: logic_res = in_src_a ^ in_src_b;
      OP_ORR:         logic_res = in_src_a | in_src_b;
      OP_MOV:         logic_res = in_src_b;
      OP_BIC:         logic_res = in_src_a & ~in_src_b;
      OP_MVN:         logic_res = ~in_src_b;
      default:        logic_res = '0;
    endcase
  end

  assign arith   = is_arith(in_opcode);
  assign alu_res = arith ? sum[31:0] : logic_res;

  // NZCV update on accepted, condition-passing flag-setting instructions
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= RESET_FLAGS;
    end else if (accept && cond_pass && (in_set_flags || is_compare(in_opcode))) begin
      flags[FLAG_N] <= alu_res[31];
      flags[FLAG_Z] <= (alu_res == 32'b0);
      if (arith) begin
        flags[FLAG_C] <= sum[32];
        flags[FLAG_V] <= ovf;
      end
    end
  end

  // result slot: load on accept, drop on flush or consume, hold on stall
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_write_reg <= '0;
      out_write_en  <= 1'b0;
      out_cond_pass <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_result    <= cond_pass ? alu_res : 32'b0;
      out_write_reg <= in_write_reg;
      out_write_en  <= cond_pass && !is_compare(in_opcode);
      out_cond_pass <= cond_pass;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARM_EXEC_PERF_CNT_EN
  // saturating counts of executed vs condition-failed accepts
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_count   <= '0;
      squash_count <= '0;
    end else if (accept) begin
      if (cond_pass && !(&exec_count))
        exec_count <= exec_count + 1'b1;
      if (!cond_pass && !(&squash_count))
        squash_count <= squash_count + 1'b1;
    end
  end
`else
  assign exec_count   = '0;
  assign squash_count = '0;
`endif

endmodule

// File: tb/tb_arm_exec_stage.sv
// Scoreboard bench for arm_exec_stage: a driver issues directed and random
// instructions, a flag/ALU model computes the expected write-back record and
// queues it; a negedge monitor pops and compares whenever a result leaves.
module tb_arm_exec_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_set_flags, flush;
  logic [3:0]  in_cond, in_opcode, in_write_reg;
  logic [31:0] in_src_a, in_src_b;
  logic        out_valid, out_ready, out_write_en, out_cond_pass;
  logic [31:0] out_result;
  logic [3:0]  out_write_reg, flags;
  logic [15:0] exec_count, squash_count;

  arm_exec_stage #(.RESET_FLAGS(4'b0000), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_opcode(in_opcode), .in_set_flags(in_set_flags),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_write_reg(in_write_reg),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_write_reg(out_write_reg),
    .out_write_en(out_write_en), .out_cond_pass(out_cond_pass),
    .flags(flags), .exec_count(exec_count), .squash_count(squash_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  wr;
    logic        we;
    logic        pass;
    logic [3:0]  fl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0, n_pass = 0;
  logic mv = 1'b0, mv_next = 1'b0;   // model: slot occupied this cycle / next
  logic [3:0] mflags = 4'b0000;
  int   m_exec = 0, m_squash = 0;
  logic started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // condition table, written straight from the ARM definitions
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy && !z;   4'h9: return !cy || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && n == v;
      4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ALU model in 64-bit integer arithmetic: C from the unsigned result range,
  // V from the signed result range
  task automatic alu_model(input logic [3:0] op, input logic [31:0] a, b,
                           input logic [3:0] f, output logic [31:0] r,
                           output logic cy, v, arith);
    logic [31:0] x, y;
    longint k, u, s;
    logic is_add;
    arith = 1'b1; cy = f[1]; v = f[0]; r = '0;
    x = a; y = b; k = 0; is_add = 1'b0;
    case (op)
      4'h0, 4'h8: begin r = a & b;  arith = 1'b0; end
      4'h1, 4'h9: begin r = a ^ b;  arith = 1'b0; end
      4'hC:       begin r = a | b;  arith = 1'b0; end
      4'hD:       begin r = b;      arith = 1'b0; end
      4'hE:       begin r = a & ~b; arith = 1'b0; end
      4'hF:       begin r = ~b;     arith = 1'b0; end
      4'h4, 4'hB: is_add = 1'b1;
      4'h5:       begin is_add = 1'b1; k = f[1] ? 1 : 0; end
      4'h6:       k = f[1] ? 0 : 1;
      4'h3:       begin x = b; y = a; end
      4'h7:       begin x = b; y = a; k = f[1] ? 0 : 1; end
      default: ;  // SUB, CMP
    endcase
    if (arith) begin
      if (is_add) begin
        u = longint'(x) + longint'(y) + k;
        s = longint'($signed(x)) + longint'($signed(y)) + k;
        cy = (u > 64'sh0000_0000_FFFF_FFFF);
      end else begin
        u = longint'(x) - longint'(y) - k;
        s = longint'($signed(x)) - longint'($signed(y)) - k;
        cy = (longint'(x) >= longint'(y) + k);
      end
      r = u[31:0];
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endtask

  // one cycle of stimulus; the model decides acceptance from its own view
  task automatic step(input logic iv, input logic [3:0] c, op, input logic s,
                      input logic [31:0] a, b, input logic [3:0] wr,
                      input logic ordy, fl);
    logic exp_ready, acc, pass, cy, v, arith;
    logic [31:0] r;
    exp_t e;
    @(posedge clk); #1;
    mv = mv_next;
    in_valid = iv; in_cond = c; in_opcode = op; in_set_flags = s;
    in_src_a = a; in_src_b = b; in_write_reg = wr; out_ready = ordy; flush = fl;
    #1;
    exp_ready = !fl && (!mv || ordy);
    check("in_ready", in_ready, exp_ready);
    acc = iv && exp_ready;
    if (acc) begin
      pass = cond_ok(c, mflags);
      alu_model(op, a, b, mflags, r, cy, v, arith);
      if (pass) m_exec++; else m_squash++;
      if (pass && (s || op inside {[4'h8:4'hB]})) begin
        mflags[3] = r[31];
        mflags[2] = (r == 32'b0);
        if (arith) begin mflags[1] = cy; mflags[0] = v; end
      end
      e.res = pass ? r : 32'b0; e.wr = wr; e.pass = pass; e.fl = mflags;
      e.we = pass && !(op inside {[4'h8:4'hB]});
      q.push_back(e);
    end
    mv_next = fl ? 1'b0 : (acc ? 1'b1 : (ordy ? 1'b0 : mv));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    q.delete(); mv = 1'b0; mv_next = 1'b0; mflags = 4'b0000;
    m_exec = 0; m_squash = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_result"}, out_result, 32'b0);
    check({tag, "_out_write_reg"}, out_write_reg, 4'b0);
    check({tag, "_out_write_en"}, out_write_en, 1'b0);
    check({tag, "_out_cond_pass"}, out_cond_pass, 1'b0);
    check({tag, "_flags"}, flags, 4'b0000);
    check({tag, "_exec_count"}, exec_count, 16'd0);
    check({tag, "_squash_count"}, squash_count, 16'd0);
  endtask

  // monitor: pop one expected record per departing (or flushed) result
  always @(negedge clk) begin
    if (started && !reset) begin
      check("out_valid", out_valid, mv);
      if (mv && (flush || out_ready)) begin
        if (q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (!flush) begin
            check("out_result", out_result, e.res);
            check("out_write_reg", out_write_reg, e.wr);
            check("out_write_en", out_write_en, e.we);
            check("out_cond_pass", out_cond_pass, e.pass);
            check("flags", flags, e.fl);
          end
        end
      end
    end
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_cond = 4'hE; in_opcode = 4'h0;
    in_set_flags = 1'b0; in_src_a = '0; in_src_b = '0; in_write_reg = '0;
    out_ready = 1'b1; flush = 1'b0;
    do_reset();
    check_reset_state("reset");
    check("reset_in_ready", in_ready, 1'b1);
    started = 1'b1;

    // ADDS 5+7, CMP 3,3, MOVEQ, MOVNE
    step(1, 4'hE, 4'h4, 1, 32'd5, 32'd7, 4'd1, 1, 0);
    step(1, 4'hE, 4'hA, 0, 32'd3, 32'd3, 4'd2, 1, 0);
    check("add_result", out_result, 32'd12);
    check("add_flags", flags, 4'b0000);
    step(1, 4'h0, 4'hD, 0, 32'd0, 32'hAB, 4'd3, 1, 0);
    check("cmp_flags", flags, 4'b0110);
    check("cmp_write_en", out_write_en, 1'b0);
    step(1, 4'h1, 4'hD, 0, 32'd0, 32'hCD, 4'd4, 1, 0);
    check("moveq_result", out_result, 32'hAB);
    // signed overflow then unsigned carry-out to zero
    step(1, 4'hE, 4'h4, 1, 32'h7FFF_FFFF, 32'd1, 4'd5, 1, 0);
    check("movne_result", out_result, 32'd0);
    check("movne_write_en", out_write_en, 1'b0);
    step(1, 4'hE, 4'h4, 1, 32'hFFFF_FFFF, 32'd1, 4'd6, 1, 0);
    check("adds_ovf_flags", flags, 4'b1001);
    step(0, 4'hE, 4'h0, 0, 32'd0, 32'd0, 4'd0, 1, 0);
    check("adds_carry_flags", flags, 4'b0110);

    // stall 3 cycles with in_valid held, then release
    step(1, 4'hE, 4'hC, 0, 32'h10, 32'h01, 4'd7, 0, 0);
    repeat (3) step(1, 4'hE, 4'h4, 0, 32'd1, 32'd1, 4'd8, 0, 0);
    repeat (3) step(1, 4'hE, 4'h4, 0, 32'd2, 32'd2, 4'd9, 1, 0);

    // flush while stalled
    step(1, 4'hE, 4'hD, 0, 32'd0, 32'h55, 4'd10, 0, 0);
    step(1, 4'hE, 4'hD, 0, 32'd0, 32'h66, 4'd11, 0, 1);
    step(0, 4'hE, 4'h0, 0, 32'd0, 32'd0, 4'd0, 1, 0);

    // reset while stalled
    step(1, 4'hE, 4'h4, 1, 32'hFFFF_FFFF, 32'd1, 4'd12, 0, 0);
    step(0, 4'hE, 4'h0, 0, 32'd0, 32'd0, 4'd0, 0, 0);
    do_reset();
    check_reset_state("midstall_reset");

    // counters: 4 AL + 2 NV
    repeat (4) step(1, 4'hE, 4'hD, 0, 32'd0, 32'd9, 4'd1, 1, 0);
    repeat (2) step(1, 4'hF, 4'hD, 0, 32'd0, 32'd9, 4'd1, 1, 0);
    step(0, 4'hE, 4'h0, 0, 32'd0, 32'd0, 4'd0, 1, 0);
`ifdef ARM_EXEC_PERF_CNT_EN
    check("exec_count_4", exec_count, 16'd4);
    check("squash_count_2", squash_count, 16'd2);
`else
    check("exec_count_off", exec_count, 16'd0);
    check("squash_count_off", squash_count, 16'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 8,
           ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           pick_val(), pick_val(), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (3) step(0, 4'hE, 4'h0, 0, 32'd0, 32'd0, 4'd0, 1, 0);
    check("scoreboard_drained", q.size(), 0);
`ifdef ARM_EXEC_PERF_CNT_EN
    check("exec_count_rand", exec_count, 16'(m_exec));
    check("squash_count_rand", squash_count, 16'(m_squash));
`else
    check("exec_count_rand_off", exec_count, 16'd0);
    check("squash_count_rand_off", squash_count, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
